// File: rtl/mips_fwd_pkg.sv
// Shared definitions for the operand-forwarding controller.
//   FWD_* : encodings of the 2-bit ALU-operand mux select
//   slot_t: one shadow pipeline slot {valid, rd, reg_write, mem_read}
package mips_fwd_pkg;

  localparam int unsigned DEF_REG_ADDR_WIDTH = 5;

  localparam logic [1:0] FWD_REG   = 2'b00;  // register file / ID-EX value
  localparam logic [1:0] FWD_EXMEM = 2'b01;  // EX/MEM ALU result
  localparam logic [1:0] FWD_MEMWB = 2'b10;  // MEM/WB write-back value

  typedef struct packed {
    logic                          valid;
    logic [DEF_REG_ADDR_WIDTH-1:0] rd;
    logic                          reg_write;
    logic                          mem_read;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '0;

  // A slot whose result can be forwarded: real, writing, and not targeting the zero register.
  function automatic logic is_live_writer(slot_t s, logic [DEF_REG_ADDR_WIDTH-1:0] zero_reg);
    return s.valid & s.reg_write & (s.rd != zero_reg);
  endfunction

endpackage

// File: rtl/fwd_src_sel.sv
// Per-operand forwarding select, combinational.
//   use_src  : the ID instruction reads this operand
//   src      : ID source register specifier
//   ex_live  : EX slot is a live writer;  ex_rd : its destination
//   mem_live : MEM slot is a live writer; mem_rd: its destination
//   sel      : FWD_REG / FWD_EXMEM / FWD_MEMWB
module fwd_src_sel
  import mips_fwd_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int unsigned ZERO_REG       = 0
) (
  input  logic                      use_src,
  input  logic [REG_ADDR_WIDTH-1:0] src,
  input  logic                      ex_live,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      mem_live,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
  output logic [1:0]                sel
);

  localparam logic [REG_ADDR_WIDTH-1:0] ZeroReg = REG_ADDR_WIDTH'(ZERO_REG);

  always_comb begin
    sel = FWD_REG;
    if (!use_src || src == ZeroReg) begin
      sel = FWD_REG;
    end else if (ex_live && ex_rd == src) begin
      // Newest producer wins over the older one in MEM.
      sel = FWD_EXMEM;
    end else if (mem_live && mem_rd == src) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_ctrl.sv
// Forwarding / load-use hazard controller beside the ID/EX pipeline register.
// Keeps a shadow EX/MEM/WB scoreboard of in-flight destinations and registers
// the ALU operand mux selects for the instruction entering EX.
//   clk, rst            : clock, asynchronous active-high reset
//   id_*                : decoded fields of the instruction in ID
//   flush               : kill the ID instruction (redirect)
//   stall               : combinational load-use stall (hold PC/IF-ID, bubble EX)
//   fwd_a_sel/fwd_b_sel : registered operand mux selects for the EX instruction
//   ex_valid            : EX slot holds a real instruction
module fwd_ctrl
  import mips_fwd_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int unsigned ZERO_REG       = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic                      id_use_rs,
  input  logic                      id_use_rt,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic                      flush,
  output logic                      stall,
  output logic [1:0]                fwd_a_sel,
  output logic [1:0]                fwd_b_sel,
  output logic                      ex_valid
);

  localparam logic [REG_ADDR_WIDTH-1:0] ZeroReg = REG_ADDR_WIDTH'(ZERO_REG);

  slot_t ex_q, mem_q, wb_q;
  slot_t id_slot;
  logic  ex_live, mem_live;
  logic  accept;
  logic  [1:0] sel_a, sel_b;
  logic  [1:0] fwd_a_q, fwd_b_q;

  assign ex_live  = is_live_writer(ex_q, ZeroReg);
  assign mem_live = is_live_writer(mem_q, ZeroReg);

  // ex_live already excludes the zero register, so a $0 load never stalls.
  always_comb begin
    stall = 1'b0;
    if (id_valid && !flush && ex_live && ex_q.mem_read) begin
      stall = (id_use_rs && id_rs == ex_q.rd) || (id_use_rt && id_rt == ex_q.rd);
    end
  end

  assign accept = id_valid & ~stall & ~flush;

  always_comb begin
    id_slot           = SLOT_EMPTY;
    id_slot.valid     = 1'b1;
    id_slot.rd        = id_rd;
    id_slot.reg_write = id_reg_write;
    id_slot.mem_read  = id_mem_read;
  end

  fwd_src_sel #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
    .ZERO_REG      (ZERO_REG)
  ) u_sel_a (
    .use_src (id_use_rs),
    .src     (id_rs),
    .ex_live (ex_live),
    .ex_rd   (ex_q.rd),
    .mem_live(mem_live),
    .mem_rd  (mem_q.rd),
    .sel     (sel_a)
  );

  fwd_src_sel #(
    .REG_ADDR_WIDTH(REG_ADDR_WIDTH),
    .ZERO_REG      (ZERO_REG)
  ) u_sel_b (
    .use_src (id_use_rt),
    .src     (id_rt),
    .ex_live (ex_live),
    .ex_rd   (ex_q.rd),
    .mem_live(mem_live),
    .mem_rd  (mem_q.rd),
    .sel     (sel_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q    <= SLOT_EMPTY;
      mem_q   <= SLOT_EMPTY;
      wb_q    <= SLOT_EMPTY;
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
    end else begin
      wb_q    <= mem_q;
      mem_q   <= ex_q;
      ex_q    <= accept ? id_slot : SLOT_EMPTY;
      fwd_a_q <= accept ? sel_a : FWD_REG;
      fwd_b_q <= accept ? sel_b : FWD_REG;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
  assign ex_valid  = ex_q.valid;

`ifndef SYNTHESIS
  // WB is tracked for completeness only (write-through covers its hazard);
  // it must always be last cycle's MEM slot.
  a_wb_follows_mem: assert property (@(posedge clk) disable iff (rst) wb_q == $past(mem_q));
  a_sel_never_11: assert property (@(posedge clk) disable iff (rst)
                                   fwd_a_q != 2'b11 && fwd_b_q != 2'b11);
`endif

endmodule

// File: tb/tb_fwd_ctrl.sv
module tb_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_use_rs, id_use_rt, id_reg_write, id_mem_read;
  logic       flush;
  logic       stall;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       ex_valid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fwd_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_rd       (id_rd),
    .id_reg_write(id_reg_write),
    .id_mem_read (id_mem_read),
    .flush       (flush),
    .stall       (stall),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .ex_valid    (ex_valid)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one ID instruction (valid=0 gives an empty ID stage).
  task automatic drive(input logic v, input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic fl);
    id_valid = v; id_rs = rs; id_use_rs = urs; id_rt = rt; id_use_rt = urt;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr; flush = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check_eq("rst_a", 32'(fwd_a_sel), 32'd0);
    check_eq("rst_b", 32'(fwd_b_sel), 32'd0);
    check_eq("rst_exv", 32'(ex_valid), 32'd0);
    check_eq("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    tick();

    // add $3,$1,$2 ; sub $4,$3,$5
    drive(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0); tick();
    drive(1, 5'd3, 1, 5'd5, 1, 5'd4, 1, 0, 0);
    check_eq("exmem_stall", 32'(stall), 32'd0);
    tick();
    check_eq("exmem_a", 32'(fwd_a_sel), 32'd1);
    check_eq("exmem_b", 32'(fwd_b_sel), 32'd0);
    check_eq("exmem_exv", 32'(ex_valid), 32'd1);
    idle(3);

    // add $3 ; xor $9,$10,$11 ; or $6,$7,$3
    drive(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0); tick();
    drive(1, 5'd10, 1, 5'd11, 1, 5'd9, 1, 0, 0); tick();
    drive(1, 5'd7, 1, 5'd3, 1, 5'd6, 1, 0, 0); tick();
    check_eq("memwb_a", 32'(fwd_a_sel), 32'd0);
    check_eq("memwb_b", 32'(fwd_b_sel), 32'd2);
    idle(3);

    // add $3 ; addi $3,$3,1 ; and $8,$3,$3
    drive(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0); tick();
    drive(1, 5'd3, 1, 5'd0, 0, 5'd3, 1, 0, 0); tick();
    check_eq("addi_a", 32'(fwd_a_sel), 32'd1);
    check_eq("addi_b", 32'(fwd_b_sel), 32'd0);
    drive(1, 5'd3, 1, 5'd3, 1, 5'd8, 1, 0, 0); tick();
    check_eq("prio_a", 32'(fwd_a_sel), 32'd1);
    check_eq("prio_b", 32'(fwd_b_sel), 32'd1);
    idle(3);

    // lw $3,0($1) ; add $4,$3,$3
    drive(1, 5'd1, 1, 5'd0, 0, 5'd3, 1, 1, 0); tick();
    drive(1, 5'd3, 1, 5'd3, 1, 5'd4, 1, 0, 0);
    #1 check_eq("lu_stall1", 32'(stall), 32'd1);
    tick();
    check_eq("lu_bub_exv", 32'(ex_valid), 32'd0);
    check_eq("lu_bub_a", 32'(fwd_a_sel), 32'd0);
    check_eq("lu_bub_b", 32'(fwd_b_sel), 32'd0);
    check_eq("lu_stall2", 32'(stall), 32'd0);
    tick();
    check_eq("lu_exv", 32'(ex_valid), 32'd1);
    check_eq("lu_a", 32'(fwd_a_sel), 32'd2);
    check_eq("lu_b", 32'(fwd_b_sel), 32'd2);
    check_eq("lu_stall3", 32'(stall), 32'd0);
    idle(3);

    // Writer to $0 then reader of $0
    drive(1, 5'd1, 1, 5'd2, 1, 5'd0, 1, 0, 0); tick();
    drive(1, 5'd0, 1, 5'd0, 1, 5'd5, 1, 0, 0);
    #1 check_eq("z_stall", 32'(stall), 32'd0);
    tick();
    check_eq("z_a", 32'(fwd_a_sel), 32'd0);
    check_eq("z_b", 32'(fwd_b_sel), 32'd0);
    idle(3);
    // Load to $0 then reader of $0
    drive(1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 1, 0); tick();
    drive(1, 5'd0, 1, 5'd0, 1, 5'd5, 1, 0, 0);
    #1 check_eq("zl_stall", 32'(stall), 32'd0);
    tick();
    check_eq("zl_exv", 32'(ex_valid), 32'd1);
    check_eq("zl_a", 32'(fwd_a_sel), 32'd0);
    idle(3);

    // Flush overrides a load-use hazard
    drive(1, 5'd1, 1, 5'd0, 0, 5'd3, 1, 1, 0); tick();
    drive(1, 5'd3, 1, 5'd3, 1, 5'd4, 1, 0, 1);
    #1 check_eq("fl_stall", 32'(stall), 32'd0);
    tick();
    check_eq("fl_exv", 32'(ex_valid), 32'd0);
    check_eq("fl_a", 32'(fwd_a_sel), 32'd0);
    check_eq("fl_b", 32'(fwd_b_sel), 32'd0);
    idle(3);
    // Flush of an ALU-dependent instruction
    drive(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0); tick();
    drive(1, 5'd3, 1, 5'd5, 1, 5'd4, 1, 0, 1); tick();
    check_eq("fl2_exv", 32'(ex_valid), 32'd0);
    check_eq("fl2_a", 32'(fwd_a_sel), 32'd0);
    idle(3);

    // Reset with two writers in flight
    drive(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0); tick();
    drive(1, 5'd3, 1, 5'd3, 1, 5'd5, 1, 0, 0); tick();
    check_eq("pre_rst_a", 32'(fwd_a_sel), 32'd1);
    drive(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0);
    rst = 1'b1;
    #1;
    check_eq("mrst_a", 32'(fwd_a_sel), 32'd0);
    check_eq("mrst_b", 32'(fwd_b_sel), 32'd0);
    check_eq("mrst_exv", 32'(ex_valid), 32'd0);
    tick();
    rst = 1'b0;
    drive(1, 5'd5, 1, 5'd3, 1, 5'd6, 1, 0, 0);
    #1 check_eq("prst_stall", 32'(stall), 32'd0);
    tick();
    check_eq("prst_exv", 32'(ex_valid), 32'd1);
    check_eq("prst_a", 32'(fwd_a_sel), 32'd0);
    check_eq("prst_b", 32'(fwd_b_sel), 32'd0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
